seqplu_monitor: RTL and testbench

Downstream checker for the four-phase sequential pulse generator. It samples the generator's 4-bit one-hot phase vector every clock and verifies that the vector is one-hot and advances 1000 → 0100 → 0010 → 0001 → 1000. It reports lock, errors and completed rotations to the control/status logic.

---
 rtl/seqplu_pkg.sv | 19 +
 rtl/seqplu_classify.sv | 19 +
 rtl/seqplu_monitor.sv | 139 +++++++++++++
 tb/tb_seqplu_monitor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seqplu_pkg.sv
// Shared types and constants for the sequential pulse monitor.
package seqplu_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } fsm_t;

  localparam logic [3:0] PH_A = 4'b1000;
  localparam logic [3:0] PH_B = 4'b0100;
  localparam logic [3:0] PH_C = 4'b0010;
  localparam logic [3:0] PH_D = 4'b0001;

  function automatic logic [3:0] next_phase(input logic [3:0] p);
    return {p[0], p[3:1]};
  endfunction

endpackage

// File: rtl/seqplu_classify.sv
// Combinational classification of one phase sample against the previous phase.
module seqplu_classify
  import seqplu_pkg::*;
(
  input  logic [3:0] prev,
  input  logic [3:0] phase,
  output logic       onehot,
  output logic       is_next,
  output logic       is_hold
);

  // Classify the sample: single-bit check, expected rotation, repeat.
  always_comb begin
    onehot  = (phase != 4'd0) && ((phase & (phase - 4'd1)) == 4'd0);
    is_next = (phase == next_phase(prev));
    is_hold = (phase == prev);
  end

endmodule

// File: rtl/seqplu_monitor.sv
// Checks a four-phase one-hot rotation, reporting lock, violations and rotations.
module seqplu_monitor
  import seqplu_pkg::*;
#(
  parameter int LOCK_N     = 4,
  parameter int ALLOW_HOLD = 1,
  parameter int EW         = 8,
  parameter int CW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    phase,
  input  logic          clr,
  output logic          locked,
  output logic          err_pulse,
  output logic          err_sticky,
  output logic [EW-1:0] err_cnt,
  output logic [CW-1:0] cycle_cnt
);

  localparam logic [3:0]    LOCK_V  = 4'(LOCK_N);
  localparam logic [EW-1:0] ERR_ONE = EW'(1'b1);
  localparam logic [EW-1:0] ERR_MAX = {EW{1'b1}};
  localparam logic [CW-1:0] CYC_ONE = CW'(1'b1);

  fsm_t          fsm_r;
  logic [3:0]    prev_r;
  logic [3:0]    good_cnt_r;
  logic          locked_r;
  logic          err_pulse_r;
  logic          err_sticky_r;
  logic [EW-1:0] err_cnt_r;
  logic [CW-1:0] cycle_cnt_r;

  logic onehot_s;
  logic is_next_s;
  logic is_hold_s;
  logic hold_ok_s;
  logic [EW-1:0] err_inc_s;

  seqplu_classify u_classify (
    .prev    (prev_r),
    .phase   (phase),
    .onehot  (onehot_s),
    .is_next (is_next_s),
    .is_hold (is_hold_s)
  );

  // Legal-hold qualifier and saturating error increment; clr restarts the count at one.
  always_comb begin
    hold_ok_s = is_hold_s && (ALLOW_HOLD != 0);
    if (clr) begin
      err_inc_s = ERR_ONE;
    end else if (err_cnt_r == ERR_MAX) begin
      err_inc_s = ERR_MAX;
    end else begin
      err_inc_s = err_cnt_r + ERR_ONE;
    end
  end

  // Lock FSM with registered status outputs; event updates below override clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_r        <= SEARCH;
      prev_r       <= 4'd0;
      good_cnt_r   <= 4'd0;
      locked_r     <= 1'b0;
      err_pulse_r  <= 1'b0;
      err_sticky_r <= 1'b0;
      err_cnt_r    <= '0;
      cycle_cnt_r  <= '0;
    end else begin
      err_pulse_r <= 1'b0;
      if (clr) begin
        err_sticky_r <= 1'b0;
        err_cnt_r    <= '0;
        cycle_cnt_r  <= '0;
      end
      case (fsm_r)
        SEARCH: begin
          if (onehot_s) begin
            prev_r     <= phase;
            good_cnt_r <= 4'd0;
            fsm_r      <= ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (is_next_s) begin
            prev_r     <= phase;
            good_cnt_r <= good_cnt_r + 4'd1;
            if ((good_cnt_r + 4'd1) == LOCK_V) begin
              fsm_r    <= LOCKED;
              locked_r <= 1'b1;
            end
          end else if (!hold_ok_s) begin
            good_cnt_r <= 4'd0;
            if (onehot_s) begin
              prev_r <= phase;
            end else begin
              fsm_r <= SEARCH;
            end
          end
        end
        LOCKED: begin
          if (is_next_s) begin
            prev_r <= phase;
            if (prev_r == PH_D) begin
              cycle_cnt_r <= clr ? CYC_ONE : (cycle_cnt_r + CYC_ONE);
            end
          end else if (!hold_ok_s) begin
            err_pulse_r  <= 1'b1;
            err_sticky_r <= 1'b1;
            err_cnt_r    <= err_inc_s;
            locked_r     <= 1'b0;
            good_cnt_r   <= 4'd0;
            if (onehot_s) begin
              prev_r <= phase;
              fsm_r  <= ACQUIRE;
            end else begin
              fsm_r <= SEARCH;
            end
          end
        end
        default: begin
          fsm_r      <= SEARCH;
          locked_r   <= 1'b0;
          good_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  assign locked     = locked_r;
  assign err_pulse  = err_pulse_r;
  assign err_sticky = err_sticky_r;
  assign err_cnt    = err_cnt_r;
  assign cycle_cnt  = cycle_cnt_r;

endmodule

// File: tb/tb_seqplu_monitor.sv
// Directed bench for seqplu_monitor: default instance plus a no-hold instance.
module tb_seqplu_monitor;

  logic        clk;
  logic        rst;
  logic [3:0]  phase;
  logic [3:0]  phase_h;
  logic        clr;
  logic        locked, err_pulse, err_sticky;
  logic [7:0]  err_cnt;
  logic [15:0] cycle_cnt;
  logic        locked_h, err_pulse_h, err_sticky_h;
  logic [7:0]  err_cnt_h;
  logic [15:0] cycle_cnt_h;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] p;

  seqplu_monitor #(.LOCK_N(4), .ALLOW_HOLD(1), .EW(8), .CW(16)) dut (
    .clk(clk), .rst(rst), .phase(phase), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .err_cnt(err_cnt), .cycle_cnt(cycle_cnt)
  );

  seqplu_monitor #(.LOCK_N(4), .ALLOW_HOLD(0), .EW(8), .CW(16)) dut_nh (
    .clk(clk), .rst(rst), .phase(phase_h), .clr(clr),
    .locked(locked_h), .err_pulse(err_pulse_h), .err_sticky(err_sticky_h),
    .err_cnt(err_cnt_h), .cycle_cnt(cycle_cnt_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] rot(input logic [3:0] x);
    return {x[0], x[3:1]};
  endfunction

  task automatic cyc(input logic [3:0] v);
    phase = v;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_h(input logic [3:0] v);
    phase_h = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b exp 0", locked); end
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse got %b exp 0", err_pulse); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err_sticky got %b exp 0", err_sticky); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
    n_checks++; if (cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cycle_cnt got %0d exp 0", cycle_cnt); end
    n_checks++; if (dut.fsm_r !== 2'd0) begin n_fail++; $display("FAIL reset_fsm got %0d exp 0", dut.fsm_r); end
    n_checks++; if (locked_h !== 1'b0 || err_cnt_h !== 8'd0) begin n_fail++; $display("FAIL reset_nh got locked %b cnt %0d exp 0 0", locked_h, err_cnt_h); end
    rst = 1'b1;
  endtask

  task automatic test_lock();
    cyc(4'b1000);
    cyc(4'b1000);
    cyc(4'b0100);
    cyc(4'b0010);
    cyc(4'b0001);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early got %b exp 0", locked); end
    cyc(4'b1000);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_4th got %b exp 1", locked); end
    cyc(4'b0100);
    cyc(4'b0010);
    cyc(4'b0001);
    n_checks++; if (cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL cycle_before got %0d exp 0", cycle_cnt); end
    cyc(4'b1000);
    n_checks++; if (cycle_cnt !== 16'd1) begin n_fail++; $display("FAIL cycle_first got %0d exp 1", cycle_cnt); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL lock_sticky got %b exp 0", err_sticky); end
  endtask

  task automatic test_error();
    cyc(4'b0100);
    cyc(4'b0011);
    n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL err_pulse got %b exp 1", err_pulse); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL err_cnt1 got %0d exp 1", err_cnt); end
    n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", err_sticky); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL err_unlock got %b exp 0", locked); end
    n_checks++; if (dut.fsm_r !== 2'd0) begin n_fail++; $display("FAIL err_fsm got %0d exp 0", dut.fsm_r); end
    cyc(4'b0011);
    n_checks++; if (err_pulse !== 1'b0 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL err_single got pulse %b cnt %0d exp 0 1", err_pulse, err_cnt); end
    cyc(4'b0010);
    cyc(4'b0001);
    cyc(4'b1000);
    cyc(4'b0100);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early got %b exp 0", locked); end
    cyc(4'b0010);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock got %b exp 1", locked); end
  endtask

  task automatic test_skip();
    cyc(4'b0001);
    cyc(4'b1000);
    n_checks++; if (cycle_cnt !== 16'd2) begin n_fail++; $display("FAIL cycle_second got %0d exp 2", cycle_cnt); end
    cyc(4'b0100);
    cyc(4'b0001);
    n_checks++; if (err_cnt !== 8'd2 || err_pulse !== 1'b1) begin n_fail++; $display("FAIL skip_err got cnt %0d pulse %b exp 2 1", err_cnt, err_pulse); end
    n_checks++; if (dut.fsm_r !== 2'd1 || dut.prev_r !== 4'b0001) begin n_fail++; $display("FAIL skip_state got fsm %0d prev %b exp 1 0001", dut.fsm_r, dut.prev_r); end
    cyc(4'b1000);
    n_checks++; if (dut.good_cnt_r !== 4'd1) begin n_fail++; $display("FAIL skip_good got %0d exp 1", dut.good_cnt_r); end
  endtask

  task automatic test_no_hold();
    cyc_h(4'b1000);
    cyc_h(4'b0100);
    cyc_h(4'b0010);
    cyc_h(4'b0001);
    cyc_h(4'b1000);
    n_checks++; if (locked_h !== 1'b1) begin n_fail++; $display("FAIL nh_lock got %b exp 1", locked_h); end
    cyc_h(4'b0100);
    cyc_h(4'b0010);
    cyc_h(4'b0010);
    n_checks++; if (err_cnt_h !== 8'd1 || err_pulse_h !== 1'b1 || locked_h !== 1'b0) begin n_fail++; $display("FAIL nh_hold got cnt %0d pulse %b locked %b exp 1 1 0", err_cnt_h, err_pulse_h, locked_h); end
    cyc_h(4'b0010);
    n_checks++; if (err_cnt_h !== 8'd1 || err_pulse_h !== 1'b0) begin n_fail++; $display("FAIL nh_hold2 got cnt %0d pulse %b exp 1 0", err_cnt_h, err_pulse_h); end
  endtask

  task automatic lock_from_p();
    for (int k = 0; k < 4; k++) begin
      p = rot(p);
      cyc(p);
    end
  endtask

  task automatic test_saturate_clr();
    cyc(4'b0011);
    n_checks++; if (err_cnt !== 8'd2 || dut.fsm_r !== 2'd0) begin n_fail++; $display("FAIL acq_bad got cnt %0d fsm %0d exp 2 0", err_cnt, dut.fsm_r); end
    p = 4'b1000;
    cyc(p);
    for (int i = 0; i < 253; i++) begin
      lock_from_p();
      p = rot(rot(p));
      cyc(p);
    end
    n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_reach got %0d exp 255", err_cnt); end
    lock_from_p();
    cyc(p);
    n_checks++; if (err_pulse !== 1'b0 || locked !== 1'b1) begin n_fail++; $display("FAIL locked_hold got pulse %b locked %b exp 0 1", err_pulse, locked); end
    p = rot(rot(p));
    cyc(p);
    n_checks++; if (err_cnt !== 8'd255 || err_pulse !== 1'b1) begin n_fail++; $display("FAIL sat_hold got cnt %0d pulse %b exp 255 1", err_cnt, err_pulse); end
    lock_from_p();
    clr = 1'b1;
    p = rot(rot(p));
    cyc(p);
    n_checks++; if (err_cnt !== 8'd1 || err_sticky !== 1'b1) begin n_fail++; $display("FAIL clr_viol got cnt %0d sticky %b exp 1 1", err_cnt, err_sticky); end
    n_checks++; if (cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_cycle got %0d exp 0", cycle_cnt); end
    cyc(p);
    clr = 1'b0;
    n_checks++; if (err_cnt !== 8'd0 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_only got cnt %0d sticky %b exp 0 0", err_cnt, err_sticky); end
    lock_from_p();
    lock_from_p();
    n_checks++; if (cycle_cnt !== 16'd1) begin n_fail++; $display("FAIL rot_after_clr got %0d exp 1", cycle_cnt); end
    for (int k = 0; k < 4; k++) begin
      if (p != 4'b0001) begin
        p = rot(p);
        cyc(p);
      end
    end
    clr = 1'b1;
    cyc(4'b1000);
    clr = 1'b0;
    n_checks++; if (cycle_cnt !== 16'd1) begin n_fail++; $display("FAIL clr_rot got %0d exp 1", cycle_cnt); end
  endtask

  task automatic test_reset_mid();
    cyc(4'b0100);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL pre_rst_lock got %b exp 1", locked); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (locked !== 1'b0 || err_pulse !== 1'b0 || err_sticky !== 1'b0 || err_cnt !== 8'd0 || cycle_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rst_async got %b %b %b %0d %0d exp all 0", locked, err_pulse, err_sticky, err_cnt, cycle_cnt);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    cyc(4'b0010);
    cyc(4'b0001);
    cyc(4'b1000);
    cyc(4'b0100);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_relock_early got %b exp 0", locked); end
    cyc(4'b0010);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL rst_relock got %b exp 1", locked); end
  endtask

  initial begin
    rst = 1'b0;
    phase = 4'b0000;
    phase_h = 4'b0000;
    clr = 1'b0;
    test_reset();
    test_lock();
    test_error();
    test_skip();
    test_no_hold();
    test_saturate_clr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
